// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: arbiter state, request record and
// default port widths.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 9;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic {
        ARB   = 1'b0,
        DLOCK = 1'b1
    } arb_state_t;

    // Sized by the package defaults; the arbiter is instantiated at those widths.
    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_rsp_route.sv
// Carries the {is_read, owner} tag two cycles alongside each accepted access and
// steers the returning memory read data to the requester that issued it.
module dmem_rsp_route #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acc,
    input  logic              is_read,
    input  logic              owner,
    input  logic [DATA_W-1:0] rd_data,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata
);

    logic              vld_p1;
    logic              vld_p2;
    logic              owner_p1;
    logic              owner_p2;
    logic [DATA_W-1:0] c_hold;
    logic [DATA_W-1:0] d_hold;

    always_ff @(posedge clk) begin
        owner_p1 <= owner;
        owner_p2 <= owner_p1;
        if (reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            c_hold <= '0;
            d_hold <= '0;
        end else begin
            // p1: strobe cycle; p2: memory returns rd_data
            vld_p1 <= acc & is_read;
            vld_p2 <= vld_p1;
            if (c_rvalid) c_hold <= rd_data;
            if (d_rvalid) d_hold <= rd_data;
        end
    end

    // Read data is passed straight through in its valid cycle and held afterwards.
    assign c_rvalid = vld_p2 & ~owner_p2;
    assign d_rvalid = vld_p2 & owner_p2;
    assign c_rdata  = c_rvalid ? rd_data : c_hold;
    assign d_rdata  = d_rvalid ? rd_data : d_hold;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: core has fixed priority, debug gets a
// starvation boost after MAX_WAIT denied cycles and can lock the port for bursts.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_stall,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              wr,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    arb_state_t state;
    arb_state_t state_nx;
    logic [3:0] wait_cnt;
    logic [3:0] wait_nx;
    mem_req_t   win_p0;
    logic       acc_p0;

    always_comb begin
        c_gnt    = 1'b0;
        d_gnt    = 1'b0;
        state_nx = state;
        wait_nx  = wait_cnt;
        case (state)
            ARB: begin
                if (d_req && wait_cnt == WAIT_MAX) d_gnt = 1'b1;
                else if (c_req)                    c_gnt = 1'b1;
                else if (d_req)                    d_gnt = 1'b1;

                if (d_req && !d_gnt)
                    wait_nx = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 4'd1;
                else
                    wait_nx = '0;

                if (d_gnt && d_lock) state_nx = DLOCK;
            end
            DLOCK: begin
                // Core is shut out for the whole burst; d_gnt follows d_req.
                d_gnt   = d_req;
                wait_nx = '0;
                if (!d_req || !d_lock) state_nx = ARB;
            end
            default: state_nx = ARB;
        endcase
    end

    always_comb begin
        acc_p0 = c_gnt | d_gnt;
        if (d_gnt) begin
            win_p0.we    = d_we;
            win_p0.addr  = d_addr;
            win_p0.wdata = d_wdata;
        end else begin
            win_p0.we    = c_we;
            win_p0.addr  = c_addr;
            win_p0.wdata = c_wdata;
        end
    end

    assign c_stall = c_req & ~c_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB;
            wait_cnt <= '0;
            wr       <= 1'b0;
            rd       <= 1'b0;
            addr     <= '0;
            wr_data  <= '0;
        end else begin
            // accept stage -> registered memory strobes
            state    <= state_nx;
            wait_cnt <= wait_nx;
            wr       <= acc_p0 & win_p0.we;
            rd       <= acc_p0 & ~win_p0.we;
            if (acc_p0) begin
                addr    <= win_p0.addr;
                wr_data <= win_p0.wdata;
            end
        end
    end

    dmem_rsp_route #(
        .DATA_W (DATA_W)
    ) u_rsp_route (
        .clk      (clk),
        .reset    (reset),
        .acc      (acc_p0),
        .is_read  (~win_p0.we),
        .owner    (d_gnt),
        .rd_data  (rd_data),
        .c_rvalid (c_rvalid),
        .c_rdata  (c_rdata),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory
// (registered read, one cycle after rd).
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, d_req, d_we, d_lock;
    logic [8:0]  c_addr, d_addr, addr;
    logic [31:0] c_wdata, d_wdata, wr_data, c_rdata, d_rdata;
    logic [31:0] rd_data = '0;
    logic        c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid, wr, rd;

    logic        pl_en = 1'b0;
    logic [8:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] mem [0:511];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (wr) mem[addr] <= wr_data;
        if (rd) rd_data <= mem[addr];
    end

    dmem_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_lock = 0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        tick();
        tick();
        reset = 0;
        #2;
        checks++; if ({wr, rd} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b required=00", {wr, rd}); end
        checks++; if (addr !== 9'd0) begin failures++; $display("FAIL reset_addr got=%0d required=0", addr); end
        checks++; if (wr_data !== 32'd0) begin failures++; $display("FAIL reset_wr_data got=%h required=0", wr_data); end
        checks++; if ({c_rvalid, d_rvalid} !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%b required=00", {c_rvalid, d_rvalid}); end
        checks++; if ({c_rdata, d_rdata} !== 64'd0) begin failures++; $display("FAIL reset_rdata got=%h/%h required=0/0", c_rdata, d_rdata); end
        checks++; if ({c_gnt, d_gnt, c_stall} !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b required=000", {c_gnt, d_gnt, c_stall}); end
    endtask

    task automatic test_core_read();
        tick();
        pl_en = 1; pl_addr = 9'd12; pl_data = 32'hDEADBEEF;
        tick();
        pl_en = 0;
        c_req = 1; c_we = 0; c_addr = 9'd12;
        #2;
        checks++; if ({c_gnt, d_gnt, c_stall} !== 3'b100) begin failures++; $display("FAIL cread_gnt got=%b required=100", {c_gnt, d_gnt, c_stall}); end
        tick();
        idle_inputs();
        #2;
        checks++; if ({wr, rd} !== 2'b01 || addr !== 9'd12) begin failures++; $display("FAIL cread_strobe got wr/rd=%b addr=%0d required=01 12", {wr, rd}, addr); end
        checks++; if (c_rvalid !== 1'b0) begin failures++; $display("FAIL cread_early_rvalid got=%b required=0", c_rvalid); end
        tick();
        #2;
        checks++; if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL cread_data got v=%b d=%h required=1 DEADBEEF", c_rvalid, c_rdata); end
        checks++; if ({wr, rd, d_rvalid} !== 3'b000) begin failures++; $display("FAIL cread_quiet got=%b required=000", {wr, rd, d_rvalid}); end
        tick();
        #2;
        checks++; if (c_rvalid !== 1'b0 || c_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL cread_hold got v=%b d=%h required=0 DEADBEEF", c_rvalid, c_rdata); end
    endtask

    task automatic test_starvation();
        logic [8:0] ea;
        for (int i = 0; i < 6; i++) begin
            tick();
            c_req = 1; c_we = 1; c_addr = 9'd100; c_wdata = 32'h100;
            d_req = 1; d_we = 1; d_lock = 0; d_addr = 9'd200; d_wdata = 32'h200;
            #2;
            checks++; if ({c_gnt, d_gnt, c_stall} !== {(i != 4), (i == 4), (i == 4)}) begin
                failures++; $display("FAIL starve_gnt cyc=%0d got=%b required=%b", i, {c_gnt, d_gnt, c_stall}, {(i != 4), (i == 4), (i == 4)});
            end
            if (i >= 1) begin
                ea = (i == 5) ? 9'd200 : 9'd100;
                checks++; if (wr !== 1'b1 || addr !== ea) begin failures++; $display("FAIL starve_strobe cyc=%0d got wr=%b addr=%0d required=1 %0d", i, wr, addr, ea); end
            end
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_debug_burst();
        int beat;
        int prev;
        logic [8:0]  ea;
        logic [31:0] ed;
        for (int i = 0; i < 10; i++) begin
            tick();
            beat = (i < 4) ? 0 : ((i < 8) ? i - 4 : 3);
            c_req = (i < 9); c_we = 1; c_addr = 9'd300; c_wdata = 32'h55;
            d_req = (i < 8); d_we = 1; d_lock = (beat < 3);
            d_addr = 9'(beat); d_wdata = 32'(beat + 1);
            #2;
            checks++; if ({c_gnt, d_gnt, c_stall} !== {(i < 4 || i == 8), (i >= 4 && i < 8), (i >= 4 && i < 8)}) begin
                failures++; $display("FAIL burst_gnt cyc=%0d got=%b required=%b", i, {c_gnt, d_gnt, c_stall}, {(i < 4 || i == 8), (i >= 4 && i < 8), (i >= 4 && i < 8)});
            end
            if (i >= 1) begin
                prev = i - 1;
                if (prev >= 4 && prev <= 7) begin ea = 9'(prev - 4); ed = 32'(prev - 3); end
                else begin ea = 9'd300; ed = 32'h55; end
                checks++; if ({wr, rd} !== 2'b10 || addr !== ea || wr_data !== ed) begin
                    failures++; $display("FAIL burst_strobe cyc=%0d got wr/rd=%b addr=%0d data=%h required=10 %0d %h", i, {wr, rd}, addr, wr_data, ea, ed);
                end
            end
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        tick();
        c_req = 1; c_we = 1; c_addr = 9'd5; c_wdata = 32'h0000_00AA;
        #2;
        checks++; if (c_gnt !== 1'b1) begin failures++; $display("FAIL b2b_wgnt got=%b required=1", c_gnt); end
        tick();
        c_req = 1; c_we = 0; c_addr = 9'd5; c_wdata = 32'h0;
        #2;
        checks++; if (c_gnt !== 1'b1) begin failures++; $display("FAIL b2b_rgnt got=%b required=1", c_gnt); end
        checks++; if ({wr, rd} !== 2'b10 || addr !== 9'd5 || wr_data !== 32'hAA) begin failures++; $display("FAIL b2b_wr got=%b addr=%0d data=%h required=10 5 AA", {wr, rd}, addr, wr_data); end
        tick();
        idle_inputs();
        #2;
        checks++; if ({wr, rd} !== 2'b01 || addr !== 9'd5) begin failures++; $display("FAIL b2b_rd got=%b addr=%0d required=01 5", {wr, rd}, addr); end
        tick();
        #2;
        checks++; if (c_rvalid !== 1'b1 || c_rdata !== 32'hAA) begin failures++; $display("FAIL b2b_rdata got v=%b d=%h required=1 AA", c_rvalid, c_rdata); end
    endtask

    task automatic test_reset_mid_read();
        tick();
        d_req = 1; d_we = 0; d_lock = 1; d_addr = 9'd12;
        #2;
        checks++; if ({c_gnt, d_gnt} !== 2'b01) begin failures++; $display("FAIL rst_dgnt got=%b required=01", {c_gnt, d_gnt}); end
        tick();
        reset = 1;
        d_req = 1; d_we = 0; d_lock = 1; d_addr = 9'd13;
        #2;
        checks++; if (rd !== 1'b1 || addr !== 9'd12) begin failures++; $display("FAIL rst_pre_rd got rd=%b addr=%0d required=1 12", rd, addr); end
        tick();
        reset = 0;
        c_req = 1; c_we = 1; c_addr = 9'd7; c_wdata = 32'h77;
        d_req = 1; d_we = 0; d_lock = 1; d_addr = 9'd13;
        #2;
        checks++; if ({wr, rd, c_rvalid, d_rvalid} !== 4'b0000) begin failures++; $display("FAIL rst_post_ctl got=%b required=0000", {wr, rd, c_rvalid, d_rvalid}); end
        checks++; if (addr !== 9'd0 || wr_data !== 32'd0) begin failures++; $display("FAIL rst_post_data got addr=%0d data=%h required=0 0", addr, wr_data); end
        checks++; if (c_rdata !== 32'd0 || d_rdata !== 32'd0) begin failures++; $display("FAIL rst_post_rdata got=%h/%h required=0/0", c_rdata, d_rdata); end
        checks++; if ({c_gnt, d_gnt} !== 2'b10 || dut.state !== ARB) begin failures++; $display("FAIL rst_nolock got gnt=%b state=%0d required=10 0", {c_gnt, d_gnt}, dut.state); end
        tick();
        idle_inputs();
        #2;
        checks++; if (d_rvalid !== 1'b0 || wr !== 1'b1 || addr !== 9'd7) begin failures++; $display("FAIL rst_after got dv=%b wr=%b addr=%0d required=0 1 7", d_rvalid, wr, addr); end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            tick();
            idle_inputs();
            #2;
            checks++; if ({wr, rd, c_gnt, d_gnt, c_stall, c_rvalid, d_rvalid} !== 7'd0 || dut.wait_cnt !== 4'd0 || addr !== 9'd7) begin
                failures++; $display("FAIL idle cyc=%0d got ctl=%b wait=%0d addr=%0d required=0 0 7", i, {wr, rd, c_gnt, d_gnt, c_stall, c_rvalid, d_rvalid}, dut.wait_cnt, addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_core_read();
        test_starvation();
        test_debug_burst();
        test_back_to_back();
        test_reset_mid_read();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (wr, rd, 9-bit addr, 32-bit wr_data/rd_data) between two requesters: the core load/store stage (port C) and a debug/loader port (port D).
- Sits between the pipeline's MEM stage and the data memory.
- Stalls the core while the debug port owns the memory.
- Arbitration:
  - Fixed priority to the core.
  - Anti-starvation boost for debug.
  - Debug lock mode for back-to-back bursts.

Parameters:
ADDR_W, 9, memory word-address width
DATA_W, 32, data width
MAX_WAIT, 4, consecutive denied debug-request cycles before debug is forced to win (1..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
c_req  in  1  core access request
c_we  in  1  core write (1) / read (0)
c_addr  in  ADDR_W  core address
c_wdata  in  DATA_W  core write data
c_gnt  out  1  core request accepted this cycle (combinational)
c_stall  out  1  c_req and not c_gnt
c_rvalid  out  1  core read data valid
c_rdata  out  DATA_W  core read data
d_req  in  1  debug access request
d_we  in  1  debug write/read
d_lock  in  1  keep ownership after this access
d_addr  in  ADDR_W  debug address
d_wdata  in  DATA_W  debug write data
d_gnt  out  1  debug request accepted this cycle (combinational)
d_rvalid  out  1  debug read data valid
d_rdata  out  DATA_W  debug read data
wr  out  1  memory write strobe (registered)
rd  out  1  memory read strobe (registered)
addr  out  ADDR_W  memory address (registered)
wr_data  out  DATA_W  memory write data (registered)
rd_data  in  DATA_W  memory read data, valid one cycle after rd

Behaviour:
- Reset values: wr=0, rd=0, addr=0, wr_data=0, c_rvalid=0, d_rvalid=0, c_rdata=0, d_rdata=0, state=ARB, wait_cnt=0.
- Reset takes effect at the next clk edge. In-flight read responses are discarded: no rvalid after reset.
- Acceptance: a request is accepted in cycle N when req and gnt are both high. Only one gnt may be high per cycle.
- Timing after acceptance in cycle N:
  - N+1: wr or rd is driven, never both. addr and wr_data are registered from the winner.
  - N+2, reads only: winner's rvalid=1 and rdata=rd_data.
- Throughput: one access per cycle, back-to-back, with no bubbles.
- Idle: with no acceptance, wr=rd=0 next cycle. addr and wr_data hold their last value.
- Per-requester rdata holds its last value when rvalid=0.
- State ARB:
  - d_req and wait_cnt==MAX_WAIT: d_gnt=1.
  - Else c_req: c_gnt=1.
  - Else d_req: d_gnt=1.
  - wait_cnt increments (saturates at MAX_WAIT) each cycle d_req=1 and d_gnt=0. It clears on d_gnt or when d_req=0.
  - Transition to DLOCK when d_gnt and d_lock.
- State DLOCK:
  - c_gnt=0; d_gnt=d_req.
  - Return to ARB when d_req=0, or when d_gnt with d_lock=0. The exit takes effect next cycle.
  - wait_cnt held at 0.
- Core stall is unbounded while debug holds the lock (intentional, debug only).
- Write-then-read to the same address in consecutive cycles needs no special handling: memory order equals accept order.
- Requester inputs are sampled only in the accept cycle. Requesters hold req and payload stable until gnt.

Decomposition:
- Shared package dmem_pkg:
  - arb_state_t enum {ARB, DLOCK}.
  - mem_req_t struct {we, addr, wdata}.
  - ADDR_W/DATA_W defaults.
- One natural sub-module: dmem_rsp_route. A 2-stage pipe carrying the {is_read, owner} tag alongside the access. It steers rd_data to c_rdata/d_rdata with the corresponding rvalid.
- Arbiter FSM, wait counter and request register stay in dmem_arbiter.

Test Plan:
- Core read, addr=9'd12, memory holds 32'hDEADBEEF, d_req=0 -> c_gnt same cycle; rd=1, addr=12 at N+1; c_rvalid=1, c_rdata=DEADBEEF at N+2; wr never high.
- c_req and d_req both held continuously, MAX_WAIT=4 -> c_gnt cycles 0-3, d_gnt cycle 4, c_gnt cycle 5; c_stall=1 only in cycle 4.
- Debug burst, d_lock=1 for writes to 9'd0..9'd3 (data 1..4), fourth with d_lock=0, c_req=1 throughout -> four consecutive d_gnt; wr=1 four cycles with addr 0..3, wr_data 1..4; c_stall=1 for those four cycles; c_gnt in the following cycle.
- Back-to-back core write 32'h0000_00AA to addr 5, then read addr 5 -> wr at N+1, rd at N+2, c_rvalid with 32'hAA at N+3.
- Reset asserted the cycle after a debug read accept -> no d_rvalid; all outputs at reset values; state ARB with no lock retained after reset release.
- Both requests idle 10 cycles -> wr=rd=0, no gnt, no rvalid; wait_cnt stays 0.
